// File: rtl/tube_hit_capture.sv
// Drift-tube hit capture: a scintillator edge opens a WINDOW-cycle drift window, then 8 per-channel words are drained.
// Latency: inputs see 2 synchronizer flops + edge detect; first word is presented in the first cycle after the window closes.
// Backpressure: out_ready low holds the current word stable; coincidences arriving while busy are counted, not queued.
module tube_hit_capture #(
    parameter int unsigned WINDOW   = 255,
    parameter logic [3:0]  LAYER_ID = 4'hC
) (
    input  logic        clk100,
    input  logic        rst_n,
    input  logic        scin_coin,
    input  logic [7:0]  tube_in,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [7:0]  missed_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN, CLEAR} state_t;

    localparam logic [7:0] LAST_CNT = 8'(WINDOW - 1);

    state_t      state, state_nxt;
    logic [1:0]  rst_pipe;
    logic        run;
    logic [8:0]  pin_meta, pin_sync, pin_prev;
    logic [8:0]  pin_edge;
    logic        scin_edge;
    logic [7:0]  tube_edge;
    logic [7:0]  win_cnt;
    logic [2:0]  ch_idx;
    logic [7:0]  hit;
    logic [7:0]  hit_time [8];

    // Reset release is retimed so the FSM cannot move until the second clock edge after rst_n rises.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign run = rst_pipe[1];

    // Two-flop synchronizer plus a history flop for rising-edge detection on all nine async pins.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            pin_meta <= '0;
            pin_sync <= '0;
            pin_prev <= '0;
        end else begin
            pin_meta <= {tube_in, scin_coin};
            pin_sync <= pin_meta;
            pin_prev <= pin_sync;
        end
    end

    assign pin_edge  = pin_sync & ~pin_prev & {9{run}};
    assign scin_edge = pin_edge[0];
    assign tube_edge = pin_edge[8:1];

    // State register; busy is registered alongside it so it tracks the state exactly.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Next-state and output decode; words are only driven while draining.
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_data  = 16'h0000;
        case (state)
            IDLE:  if (scin_edge) state_nxt = ARMED;
            ARMED: if (win_cnt == LAST_CNT) state_nxt = DRAIN;
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = {(hit[ch_idx] ? hit_time[ch_idx] : 8'hFF), LAYER_ID, ch_idx, hit[ch_idx]};
                if (out_ready && (ch_idx == 3'd7)) state_nxt = CLEAR;
            end
            CLEAR: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window counter, drain channel pointer and per-channel first-hit capture.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            ch_idx  <= '0;
            hit     <= '0;
            for (int i = 0; i < 8; i++) hit_time[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    win_cnt <= '0;
                    ch_idx  <= '0;
                end
                ARMED: begin
                    win_cnt <= win_cnt + 8'd1;
                    for (int i = 0; i < 8; i++) begin
                        if (tube_edge[i] && !hit[i]) begin
                            hit[i]      <= 1'b1;
                            hit_time[i] <= win_cnt;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) ch_idx <= ch_idx + 3'd1;
                end
                CLEAR: begin
                    hit <= '0;
                    for (int i = 0; i < 8; i++) hit_time[i] <= '0;
                end
                default: ;
            endcase
        end
    end

    // Saturating count of coincidences that arrive while an event is already in flight.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n)                                                  missed_cnt <= '0;
        else if (scin_edge && (state != IDLE) && (missed_cnt != 8'hFF)) missed_cnt <= missed_cnt + 8'd1;
    end

endmodule

// File: tb/tb_tube_hit_capture.sv
// Bench for tube_hit_capture: scheduled pin activity per event, expected words from a first-edge-in-window model.
// Pins change on the falling edge; a pin rising at offset o after the scintillator rise lands at window time o-1.
// A monitor pops expected words on each handshake and checks hold stability while out_ready is low.
module tb_tube_hit_capture;

    localparam int W      = 255;
    localparam int MAXOFF = 270;

    logic        clk100 = 1'b0;
    logic        rst_n;
    logic        scin_coin;
    logic [7:0]  tube_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [7:0]  missed_cnt;

    tube_hit_capture #(.WINDOW(W), .LAYER_ID(4'hC)) dut (
        .clk100     (clk100),
        .rst_n      (rst_n),
        .scin_coin  (scin_coin),
        .tube_in    (tube_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .missed_cnt (missed_cnt)
    );

    always #5 clk100 = ~clk100;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int ready_mode = 0;
    int ev_xfers, ev_first, ev_last, hold_run, hold_max, stall_done;
    int missed_model = 0;
    logic [15:0] sb [$];
    logic [7:0]  tsched [0:MAXOFF];
    bit          ssched [0:MAXOFF];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk100) cyc <= cyc + 1;

    // Ready pattern: 0 always high, 1 random, 2 a single 5-cycle stall while word 3 is offered.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk100);
            #1;
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (ev_xfers == 3 && stall_done < 5) begin
                        out_ready = 1'b0;
                        stall_done++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops on handshake, stability while stalled, zero data when idle.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_data;
        logic [15:0] exp;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk100);
            if (!rst_n) begin
                prev_stall = 1'b0;
                hold_run   = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(prev_data));
                end
                if (!out_valid) chk("idle_data_zero", 32'(out_data), 32'd0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL unexpected_word actual=%0h expected=none", out_data);
                    end else begin
                        exp = sb.pop_front();
                        chk("word", 32'(out_data), 32'(exp));
                    end
                    if (ev_xfers == 0) ev_first = cyc;
                    ev_last = cyc;
                    ev_xfers++;
                    hold_run = 0;
                end else if (out_valid) begin
                    hold_run++;
                    if (hold_run > hold_max) hold_max = hold_run;
                end else begin
                    hold_run = 0;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    function automatic logic [15:0] mk_word(input int ch, input bit h, input int t);
        logic [7:0] tf;
        tf = h ? 8'(t) : 8'hFF;
        return {tf, 4'hC, 3'(ch), h};
    endfunction

    task automatic clear_sched();
        for (int k = 0; k <= MAXOFF; k++) begin
            tsched[k] = '0;
            ssched[k] = 1'b0;
        end
        ssched[0] = 1'b1;
        ev_xfers   = 0;
        ev_first   = 0;
        ev_last    = 0;
        hold_max   = 0;
        stall_done = 0;
    endtask

    // Model: a channel reports the first rise whose window time (offset-1) lies in 0..W-1.
    task automatic drive_event();
        for (int ch = 0; ch < 8; ch++) begin
            int first = -1;
            for (int k = 1; k <= W; k++)
                if (first < 0 && tsched[k][ch] && !tsched[k-1][ch]) first = k;
            sb.push_back(mk_word(ch, first >= 0, first - 1));
        end
        for (int k = 1; k <= MAXOFF; k++)
            if (ssched[k] && !ssched[k-1] && missed_model < 255) missed_model++;
        for (int k = 0; k <= MAXOFF; k++) begin
            @(negedge clk100);
            scin_coin = ssched[k];
            tube_in   = tsched[k];
        end
        @(negedge clk100);
        scin_coin = 1'b0;
        tube_in   = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk100);
            n++;
        end
        if (busy) begin
            checks++;
            errs++;
            $display("FAIL busy_timeout actual=1 expected=0");
        end
        repeat (4) @(negedge clk100);
        chk("missed_cnt", 32'(missed_cnt), 32'(missed_model));
    endtask

    task automatic full_event();
        drive_event();
        wait_idle();
        chk("event_xfers", 32'(ev_xfers), 32'd8);
    endtask

    initial begin
        #2ms;
        errs++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        scin_coin = 1'b0;
        tube_in   = '0;
        repeat (3) @(negedge clk100);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_missed", 32'(missed_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk100);

        // Single hit on channel 2 at window time 40, full-rate drain.
        clear_sched();
        tsched[41][2] = 1'b1;
        full_event();
        chk("b2b_span", 32'(ev_last - ev_first), 32'd7);

        // Double pulse on channel 5: only the first (time 10) counts.
        clear_sched();
        tsched[11][5] = 1'b1;
        tsched[61][5] = 1'b1;
        full_event();

        // Five-cycle stall on word 3.
        ready_mode = 2;
        clear_sched();
        tsched[100][3] = 1'b1;
        full_event();
        chk("stall_len", 32'(hold_max), 32'd5);
        ready_mode = 0;

        // Three coincidences during the window.
        clear_sched();
        ssched[2] = 1'b1;
        ssched[4] = 1'b1;
        ssched[6] = 1'b1;
        tsched[7][6] = 1'b1;
        full_event();

        // Enough extra coincidences to saturate the counter.
        for (int e = 0; e < 3; e++) begin
            clear_sched();
            for (int k = 2; k < W; k += 2) ssched[k] = 1'b1;
            tsched[30 + e][e] = 1'b1;
            full_event();
        end

        // Window boundaries: last window cycle captured, one later missed, same-cycle-as-scin missed, first cycle captured.
        clear_sched();
        tsched[W][0]     = 1'b1;
        tsched[W + 1][1] = 1'b1;
        tsched[0][3]     = 1'b1;
        tsched[1][4]     = 1'b1;
        full_event();

        // Reset during drain after word 2.
        clear_sched();
        tsched[20][4] = 1'b1;
        fork
            drive_event();
            begin
                int n = 0;
                while (ev_xfers < 3 && n < 2000) begin
                    @(negedge clk100);
                    n++;
                end
                chk("rst_wait_word2", 32'(ev_xfers), 32'd3);
                @(posedge clk100);
                #3;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_valid", 32'(out_valid), 32'd0);
                chk("mid_rst_busy", 32'(busy), 32'd0);
                chk("mid_rst_data", 32'(out_data), 32'd0);
                chk("mid_rst_missed", 32'(missed_cnt), 32'd0);
                sb.delete();
                missed_model = 0;
                @(negedge clk100);
                @(negedge clk100);
                #2;
                rst_n = 1'b1;
            end
        join
        wait_idle();
        chk("post_rst_no_words", 32'(ev_xfers), 32'd3);
        clear_sched();
        tsched[50][0] = 1'b1;
        full_event();

        // Random pin activity with random backpressure.
        ready_mode = 1;
        for (int e = 0; e < 6; e++) begin
            clear_sched();
            for (int ch = 0; ch < 8; ch++)
                for (int k = 0; k < MAXOFF; k++)
                    if ((k == 0 || !tsched[k-1][ch]) && $urandom_range(0, 79) == 0) tsched[k][ch] = 1'b1;
            for (int k = 2; k <= W; k++)
                if (!ssched[k-1] && $urandom_range(0, 99) == 0) ssched[k] = 1'b1;
            full_event();
        end
        ready_mode = 0;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/tube_hit_capture.md
TUBE_HIT_CAPTURE -- requirements
Module: tube_hit_capture

Interface
REQ-001 SHALL have parameter WINDOW, default 255, meaning drift window length in clk100 cycles (legal 2..255).
REQ-002 SHALL have parameter LAYER_ID, default 4'hC, meaning 4-bit chamber/layer tag placed in every output word.
REQ-003 SHALL have port clk100  input  1  system 100 MHz clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port scin_coin  input  1  asynchronous scintillator coincidence pulse.
REQ-006 SHALL have port tube_in  input  8  asynchronous drift-tube discriminator pins, channel 0..7.
REQ-007 SHALL have port out_data  output  16  event word to downstream FIFO writer.
REQ-008 SHALL have port out_valid  output  1  out_data holds a word for transfer.
REQ-009 SHALL have port out_ready  input  1  downstream can accept a word this cycle.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port missed_cnt  output  8  saturating count of coincidences ignored while busy.

Function
REQ-012 SHALL pass scin_coin and each tube_in bit through a 2-flop synchronizer, then a rising-edge detector (sync=1, previous sync=0); all events below refer to detected edges.
REQ-013 SHALL implement states IDLE, ARMED, DRAIN, CLEAR.
REQ-014 IDLE: scin edge -> ARMED next cycle; window counter loaded to 0 on entry.
REQ-015 ARMED: window counter increments by 1 each cycle; on the cycle counter == WINDOW-1 -> DRAIN next cycle (ARMED lasts exactly WINDOW cycles).
REQ-016 ARMED: on a channel's first tube edge, latch hit[ch]=1 and time[ch]=current counter value; later edges on that channel within the event ignored.
REQ-017 Tube edges in IDLE, DRAIN or CLEAR SHALL NOT set hit; an edge on the ARMED cycle with counter WINDOW-1 SHALL be captured.
REQ-018 DRAIN: emit 8 words, channel 0 first through channel 7, one word per accepted handshake.
REQ-019 Word format: [15:8]=time[ch] if hit else 8'hFF; [7:4]=LAYER_ID; [3:1]=ch; [0]=hit.
REQ-020 Transfer occurs on a cycle with out_valid=1 and out_ready=1; out_valid SHALL rise in the first DRAIN cycle; out_data and out_valid SHALL stay stable while out_ready=0; next word presented the cycle after transfer (back-to-back at full throughput if out_ready held high).
REQ-021 After channel 7 transfers, out_valid=0 and state -> CLEAR for exactly 1 cycle, clearing all hit/time registers, then -> IDLE.
REQ-022 A scin edge detected in ARMED, DRAIN or CLEAR SHALL increment missed_cnt (saturating at 255) and SHALL NOT restart or extend the event.
REQ-023 Scin edge and tube edge in same IDLE cycle: event starts, tube edge not captured.
REQ-024 out_data SHALL be 16'h0000 whenever out_valid=0.
REQ-025 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, out_valid=0, out_data=0, busy=0, missed_cnt=0, all hit/time, counter and synchronizer flops 0.
REQ-027 Reset asserted mid-ARMED or mid-DRAIN SHALL abort the event with no further words; first event after release requires a fresh scin edge.
REQ-028 Reset release SHALL be synchronized internally so the first post-reset state change occurs no earlier than the second clk100 edge after rst_n rises.

Verification
REQ-029 Scin pulse, tube_in[2] rises 40 cycles after detected scin edge, out_ready=1 -> 8 words on consecutive cycles; ch2 word = 16'h28C5 (time 0x28), others 16'hFFCx with hit=0.
REQ-030 tube_in[5] pulses twice (counter 10 then 60) -> ch5 word time=0x0A only.
REQ-031 out_ready low 5 cycles during word 3 -> word 3 held unchanged 5 cycles, no word lost or duplicated, total 8 transfers.
REQ-032 Three extra scin pulses during ARMED/DRAIN -> single event output, missed_cnt=3; 260 such pulses -> missed_cnt=255.
REQ-033 Tube edge at counter WINDOW-1 (254) captured as 0xFE; edge one cycle later not captured (0xFF, hit=0).
REQ-034 rst_n pulsed low during DRAIN after word 2 -> out_valid drops asynchronously, busy=0, next scin event emits full 8 words from channel 0.
